// File: rtl/pipe_pkg.sv
// Shared types and constants for the generic pipeline stage register.
// The stage FSM encodes how many beats the stage holds: empty, one beat
// in the main register, or main plus skid entry (skid build only).
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_t;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_NUM_OPS = 3;
    localparam int DEF_CTRL_W  = 16;
    localparam int DEF_CNT_W   = 16;

    localparam int OCC_W = 2;
    localparam logic [OCC_W-1:0] OCC_EMPTY = 2'd0;
    localparam logic [OCC_W-1:0] OCC_BUSY  = 2'd1;
    localparam logic [OCC_W-1:0] OCC_FULL  = 2'd2;

    // Number of beats held in a given state; this is also what a flush
    // in that state adds to the kill counter.
    function automatic logic [OCC_W-1:0] occ_of(pipe_state_t s);
        case (s)
            ST_BUSY: return OCC_BUSY;
            ST_FULL: return OCC_FULL;
            default: return OCC_EMPTY;
        endcase
    endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One load-enabled storage entry (control bundle + operands) with a valid
// bit. Used as the main register and, in the skid build, the skid entry.
module pipe_skid_slot #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         load_i,
    input  logic         drop_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    // Valid bit: a drop (flush or drain) wins over a simultaneous load.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q <= 1'b0;
        end else if (drop_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
        end
    end

    // Payload only changes on a real load so it holds after drain or flush.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            data_q <= '0;
        end else if (load_i && !drop_i) begin
            data_q <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Flow-controlled pipeline stage register: packed control bundle plus
// NUM_OPS operand lanes, valid/ready handshake, stall, flush and a
// saturating count of beats killed by flush.
// Build option: define PIPE_SKID_EN to add a skid entry so READY_OUT is
// registered (no path from READY_IN/STALL); otherwise a single register
// with a combinational READY_OUT.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NUM_OPS = DEF_NUM_OPS,
    parameter int CTRL_W  = DEF_CTRL_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      FLUSH,
    input  logic                      STALL,
    input  logic                      VALID_IN,
    output logic                      READY_OUT,
    input  logic [CTRL_W-1:0]         CTRL_IN,
    input  logic [NUM_OPS*DATA_W-1:0] OPS_IN,
    output logic                      VALID_OUT,
    input  logic                      READY_IN,
    output logic [CTRL_W-1:0]         CTRL_OUT,
    output logic [NUM_OPS*DATA_W-1:0] OPS_OUT,
    output logic [OCC_W-1:0]          OCCUPANCY,
    output logic [CNT_W-1:0]          KILL_CNT
);

    localparam int OPS_W  = NUM_OPS * DATA_W;
    localparam int SLOT_W = CTRL_W + OPS_W;

    pipe_state_t       state_q, state_d;
    logic [OCC_W-1:0]  occ_q;
    logic [CNT_W-1:0]  kill_q, kill_d;
    logic [CNT_W:0]    kill_sum;

    logic              rdy_eff, accept, emit, ready_out;
    logic              main_load, main_drop, main_valid;
    logic [SLOT_W-1:0] main_din, main_dout, in_beat;

    assign rdy_eff = READY_IN & ~STALL;
    assign in_beat = {CTRL_IN, OPS_IN};
    assign accept  = VALID_IN & ready_out;
    assign emit    = main_valid & rdy_eff;

    // State register; occupancy is registered alongside it from the next state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_EMPTY;
            occ_q   <= OCC_EMPTY;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_of(state_d);
        end
    end

`ifdef PIPE_SKID_EN
    logic              skid_load, skid_drop, skid_valid;
    logic [SLOT_W-1:0] skid_dout;

    assign ready_out = (state_q != ST_FULL);

    // Next state: flush empties the stage, otherwise track beats held.
    always_comb begin
        state_d = state_q;
        if (FLUSH) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (accept) state_d = ST_BUSY;
                ST_BUSY: begin
                    if (accept && !emit) begin
                        state_d = ST_FULL;
                    end else if (emit && !accept) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL:  if (emit) state_d = ST_BUSY;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    // Slot controls: a beat arriving while main is stuck parks in the skid
    // entry, and the skid entry refills main first so order is preserved.
    always_comb begin
        main_load = 1'b0;
        main_drop = FLUSH;
        skid_load = 1'b0;
        skid_drop = FLUSH;
        main_din  = in_beat;
        case (state_q)
            ST_EMPTY: main_load = accept;
            ST_BUSY: begin
                main_load = accept & emit;
                skid_load = accept & ~emit;
                main_drop = FLUSH | (emit & ~accept);
            end
            ST_FULL: begin
                main_load = emit;
                skid_drop = FLUSH | emit;
            end
            default: ;
        endcase
        if (skid_valid) begin
            main_din = skid_dout;
        end
    end

    pipe_skid_slot #(.W(SLOT_W)) u_skid (
        .CLK     (CLK),
        .RST     (RST),
        .load_i  (skid_load),
        .drop_i  (skid_drop),
        .data_i  (in_beat),
        .valid_o (skid_valid),
        .data_o  (skid_dout)
    );
`else
    assign ready_out = ~main_valid | rdy_eff;

    // Next state: single register, so only empty and busy are reachable.
    always_comb begin
        state_d = state_q;
        if (FLUSH) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (accept) state_d = ST_BUSY;
                ST_BUSY:  if (emit && !accept) state_d = ST_EMPTY;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    // Slot controls: load every accepted beat, drop when drained with no refill.
    always_comb begin
        main_load = accept;
        main_drop = FLUSH | (emit & ~accept);
        main_din  = in_beat;
    end
`endif

    pipe_skid_slot #(.W(SLOT_W)) u_main (
        .CLK     (CLK),
        .RST     (RST),
        .load_i  (main_load),
        .drop_i  (main_drop),
        .data_i  (main_din),
        .valid_o (main_valid),
        .data_o  (main_dout)
    );

    // Kill counter next value: add beats held at the flush, clamp at all-ones.
    always_comb begin
        kill_sum = {1'b0, kill_q} + (CNT_W + 1)'(occ_q);
        kill_d   = kill_q;
        if (FLUSH) begin
            kill_d = kill_sum[CNT_W] ? '1 : kill_sum[CNT_W-1:0];
        end
    end

    // Kill counter register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            kill_q <= '0;
        end else begin
            kill_q <= kill_d;
        end
    end

    assign READY_OUT = ready_out;
    assign VALID_OUT = main_valid;
    assign CTRL_OUT  = main_valid ? main_dout[SLOT_W-1 -: CTRL_W] : '0;
    assign OPS_OUT   = main_dout[OPS_W-1:0];
    assign OCCUPANCY = occ_q;
    assign KILL_CNT  = kill_q;

endmodule
